// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the pipelined approximate adder.
// Low-part helpers work on a 32-bit container, so APPROX_LSB is limited to 31.
package approx_add_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } approx_mode_e;

  typedef struct packed {
    logic        carry;
    logic [31:0] low;
  } low_res_t;

  // Bits of the high part handled per pipeline stage (ceiling division).
  function automatic int seg_width(input int width, input int k, input int stages);
    return (width - k + stages - 1) / stages;
  endfunction

  // Low-part result and carry injected into the high part, per mode.
  function automatic low_res_t low_part(input logic [31:0] a_l, input logic [31:0] b_l,
                                        input int unsigned k, input logic [1:0] mode);
    low_res_t    res;
    logic [31:0] mask;
    logic [32:0] s;
    mask = 32'((33'h1 << k) - 33'h1);
    s    = {1'b0, a_l & mask} + {1'b0, b_l & mask};
    res  = '0;
    case (approx_mode_e'(mode))
      MODE_LOA: begin
        res.low   = (a_l | b_l) & mask;
        res.carry = a_l[k-1] & b_l[k-1];
      end
      MODE_TRUNC: begin
        res.low   = 32'h1 << (k - 1);
        res.carry = 1'b0;
      end
      default: begin
        res.low   = s[31:0] & mask;
        res.carry = s[k];
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/approx_add_seg.sv
// One pipeline stage: adds its slice of the high part using the carry from
// the previous stage, and carries operands/side data forward.
module approx_add_seg #(
  parameter int PW     = 4,
  parameter int SEG    = 2,
  parameter int IDX    = 0,
  parameter int SIDE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PW-1:0]     in_a,
  input  logic [PW-1:0]     in_b,
  input  logic [PW-1:0]     in_sum,
  input  logic              in_carry,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     out_a,
  output logic [PW-1:0]     out_b,
  output logic [PW-1:0]     out_sum,
  output logic              out_carry,
  output logic [SIDE_W-1:0] out_side
);

  logic [SEG:0]    seg_res;
  logic [PW-1:0]   sum_next;

  always_comb begin
    seg_res  = {1'b0, in_a[IDX*SEG +: SEG]} + {1'b0, in_b[IDX*SEG +: SEG]}
             + {{SEG{1'b0}}, in_carry};
    sum_next = in_sum;
    sum_next[IDX*SEG +: SEG] = seg_res[SEG-1:0];
  end

  // Load when empty or when the downstream stage takes our entry.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_side  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a     <= in_a;
        out_b     <= in_b;
        out_sum   <= sum_next;
        out_carry <= seg_res[SEG];
        out_side  <= in_side;
      end
    end
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder (EXACT / LOA / TRUNC) with valid/ready.
// Define APPROX_ERR_STATS_EN to add the exact-sum path and error statistics.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 4,
  parameter int STAGES     = 2,
  parameter int ERR_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [1:0]       out_mode
`ifdef APPROX_ERR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH:0]   err_max,
  output logic [ERR_W-1:0] err_sum
`endif
);

  localparam int K   = APPROX_LSB;
  localparam int HW  = WIDTH - K;
  localparam int SEG = seg_width(WIDTH, K, STAGES);
  localparam int PW  = SEG * STAGES;
`ifdef APPROX_ERR_STATS_EN
  localparam int SIDE_W = K + 2 + WIDTH + 1;
`else
  localparam int SIDE_W = K + 2;
`endif

  logic [STAGES:0] v_ch;
  logic [STAGES:0] rdy_ch;
  logic [PW-1:0]     a_ch    [STAGES+1];
  logic [PW-1:0]     b_ch    [STAGES+1];
  logic [PW-1:0]     s_ch    [STAGES+1];
  logic              c_ch    [STAGES+1];
  logic [SIDE_W-1:0] side_ch [STAGES+1];

  low_res_t lp;
  logic [PW:0] fin_full;
  logic        unused_bits;

  always_comb lp = low_part(32'(in_a[K-1:0]), 32'(in_b[K-1:0]), K, in_mode);

  // High part is zero-padded to a whole number of segments; the padding
  // bits simply absorb the carry-out.
  assign v_ch[0]   = in_valid;
  assign a_ch[0]   = PW'(in_a[WIDTH-1:K]);
  assign b_ch[0]   = PW'(in_b[WIDTH-1:K]);
  assign s_ch[0]   = '0;
  assign c_ch[0]   = lp.carry;
`ifdef APPROX_ERR_STATS_EN
  assign side_ch[0] = {({1'b0, in_a} + {1'b0, in_b}), in_mode, lp.low[K-1:0]};
`else
  assign side_ch[0] = {in_mode, lp.low[K-1:0]};
`endif
  assign rdy_ch[STAGES] = out_ready;
  assign in_ready       = rdy_ch[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    approx_add_seg #(.PW(PW), .SEG(SEG), .IDX(gi), .SIDE_W(SIDE_W)) u_seg (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_ch[gi]),
      .in_ready (rdy_ch[gi]),
      .in_a     (a_ch[gi]),
      .in_b     (b_ch[gi]),
      .in_sum   (s_ch[gi]),
      .in_carry (c_ch[gi]),
      .in_side  (side_ch[gi]),
      .out_valid(v_ch[gi+1]),
      .out_ready(rdy_ch[gi+1]),
      .out_a    (a_ch[gi+1]),
      .out_b    (b_ch[gi+1]),
      .out_sum  (s_ch[gi+1]),
      .out_carry(c_ch[gi+1]),
      .out_side (side_ch[gi+1])
    );
  end

  assign fin_full  = {c_ch[STAGES], s_ch[STAGES]};
  assign out_valid = v_ch[STAGES];
  assign out_sum   = {fin_full[HW:0], side_ch[STAGES][K-1:0]};
  assign out_mode  = side_ch[STAGES][K+1:K];
  assign unused_bits = ^{lp.low, a_ch[STAGES], b_ch[STAGES], fin_full};

`ifdef APPROX_ERR_STATS_EN
  logic [WIDTH:0] exact_sum;
  logic [WIDTH:0] abs_err;
  logic [ERR_W:0] sum_ext;

  assign exact_sum = side_ch[STAGES][SIDE_W-1 -: WIDTH+1];
  assign abs_err   = (exact_sum >= out_sum) ? exact_sum - out_sum : out_sum - exact_sum;
  assign sum_ext   = {1'b0, err_sum} + (ERR_W+1)'(abs_err);

  // Clear takes priority over a coincident output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_max   <= '0;
      err_sum   <= '0;
    end else if (stats_clr) begin
      err_count <= '0;
      err_max   <= '0;
      err_sum   <= '0;
    end else if (out_valid && out_ready) begin
      if (abs_err != '0 && err_count != '1)
        err_count <= err_count + ERR_W'(1);
      if (abs_err > err_max)
        err_max <= abs_err;
      err_sum <= sum_ext[ERR_W] ? '1 : sum_ext[ERR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed testbench for approx_add_pipe (WIDTH=8, K=4, STAGES=2).
// Stats checks are compiled in when APPROX_ERR_STATS_EN is defined.
module tb_approx_add_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [1:0] in_mode, out_mode;
  logic [8:0] out_sum;
`ifdef APPROX_ERR_STATS_EN
  logic        stats_clr;
  logic [31:0] err_count, err_sum;
  logic [8:0]  err_max;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(8), .APPROX_LSB(4), .STAGES(2), .ERR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_mode(out_mode)
`ifdef APPROX_ERR_STATS_EN
    , .stats_clr(stats_clr), .err_count(err_count), .err_max(err_max), .err_sum(err_sum)
`endif
  );

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  // Sends one operand pair into an empty pipeline and captures its result.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                         output logic [8:0] s, output logic [1:0] mo, output bit got);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0; s = '0; mo = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (out_valid) begin
        got = 1'b1; s = out_sum; mo = out_mode;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    $display("txn a=%0d b=%0d mode=%0d -> sum=%0d out_mode=%0d", a, b, m, s, mo);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_mode = '0;
`ifdef APPROX_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_sum !== 9'd0) begin bad++; $display("FAIL reset_out_sum got=%0d want=0", out_sum); end
    total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL reset_out_mode got=%0d want=0", out_mode); end
`ifdef APPROX_ERR_STATS_EN
    total++; if (err_count !== 32'd0 || err_max !== 9'd0 || err_sum !== 32'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d/%0d want=0/0/0", err_count, err_max, err_sum); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    in_a = 8'd200; in_b = 8'd100; in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL exact_in_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exact_early_valid got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL exact_latency got=%0b want=1", out_valid); end
    total++; if (out_sum !== 9'h12C) begin bad++; $display("FAIL exact_sum got=%0h want=12c", out_sum); end
    total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL exact_mode got=%0d want=0", out_mode); end
    $display("txn a=200 b=100 mode=0 -> sum=%0d out_mode=%0d", out_sum, out_mode);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exact_single_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_loa();
    logic [8:0] s; logic [1:0] mo; bit got;
    run_one(8'h0F, 8'h01, 2'd1, s, mo, got);
    total++; if (!got || s !== 9'd15) begin bad++; $display("FAIL loa_0f_01 got=%0d (valid=%0b) want=15", s, got); end
    run_one(8'h18, 8'h08, 2'd1, s, mo, got);
    total++; if (!got || s !== 9'd40) begin bad++; $display("FAIL loa_18_08 got=%0d (valid=%0b) want=40", s, got); end
    total++; if (mo !== 2'd1) begin bad++; $display("FAIL loa_mode got=%0d want=1", mo); end
`ifdef APPROX_ERR_STATS_EN
    total++; if (err_count !== 32'd2 || err_max !== 9'd8 || err_sum !== 32'd9) begin
      bad++; $display("FAIL loa_stats got=%0d/%0d/%0d want=2/8/9", err_count, err_max, err_sum); end
`endif
  endtask

  task automatic test_trunc();
    logic [8:0] s; logic [1:0] mo; bit got;
    run_one(8'h1F, 8'h2F, 2'd2, s, mo, got);
    total++; if (!got || s !== 9'h038) begin bad++; $display("FAIL trunc_sum got=%0h (valid=%0b) want=38", s, got); end
    total++; if (mo !== 2'd2) begin bad++; $display("FAIL trunc_mode got=%0d want=2", mo); end
`ifdef APPROX_ERR_STATS_EN
    total++; if (err_count !== 32'd3 || err_max !== 9'd22 || err_sum !== 32'd31) begin
      bad++; $display("FAIL trunc_stats got=%0d/%0d/%0d want=3/22/31", err_count, err_max, err_sum); end
`endif
    run_one(8'd255, 8'd255, 2'd3, s, mo, got);
    total++; if (!got || s !== 9'h1FE) begin bad++; $display("FAIL rsvd_sum got=%0h (valid=%0b) want=1fe", s, got); end
    total++; if (mo !== 2'd3) begin bad++; $display("FAIL rsvd_mode got=%0d want=3", mo); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [8:0] pe [4];
    logic [8:0] got_sum [4];
    int         got_cyc [4];
    int idx, nout;
    bit acc;
    pa = '{8'd1, 8'd3, 8'd5, 8'd7};
    pb = '{8'd2, 8'd4, 8'd6, 8'd8};
    pe = '{9'd3, 9'd7, 9'd11, 9'd15};
    idx = 0; nout = 0;
    out_ready = 1'b0; in_mode = 2'd0;
    for (int c = 0; c < 6; c++) begin
      in_a = pa[idx]; in_b = pb[idx]; in_valid = (idx < 4);
      #1;
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_a = pa[idx]; in_b = pb[idx]; in_valid = 1'b1;
    #1;
    total++; if (idx !== 2) begin bad++; $display("FAIL stall_accepted got=%0d want=2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_sum !== 9'd3) begin
      bad++; $display("FAIL stall_hold got=%0d (valid=%0b) want=3", out_sum, out_valid); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && nout < 4; cyc++) begin
      in_a = pa[idx & 3]; in_b = pb[idx & 3]; in_valid = (idx < 4);
      #1;
      acc = in_ready && in_valid;
      if (out_valid) begin
        got_sum[nout] = out_sum; got_cyc[nout] = cyc;
        $display("txn drain #%0d sum=%0d cycle=%0d", nout, out_sum, cyc);
        nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    total++; if (nout !== 4) begin bad++; $display("FAIL drain_count got=%0d want=4", nout); end
    for (int k = 0; k < nout; k++) begin
      total++; if (got_sum[k] !== pe[k]) begin bad++; $display("FAIL drain_order_%0d got=%0d want=%0d", k, got_sum[k], pe[k]); end
      total++; if (got_cyc[k] !== got_cyc[0] + k) begin
        bad++; $display("FAIL drain_b2b_%0d got=%0d want=%0d", k, got_cyc[k], got_cyc[0] + k); end
    end
  endtask

  task automatic test_reset_flight();
    bit stale;
    out_ready = 1'b0; in_mode = 2'd1; in_a = 8'h18; in_b = 8'h08; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h0F; in_b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flight_loaded got=%0b want=1", out_valid); end
    #2; rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_rst_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flight_rst_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL flight_stale got=1 want=0"); end
    total++; if (out_sum !== 9'd0) begin bad++; $display("FAIL flight_sum got=%0d want=0", out_sum); end
`ifdef APPROX_ERR_STATS_EN
    total++; if (err_count !== 32'd0 || err_max !== 9'd0 || err_sum !== 32'd0) begin
      bad++; $display("FAIL flight_stats got=%0d/%0d/%0d want=0/0/0", err_count, err_max, err_sum); end
`endif
    $display("txn reset with 2 in flight, stale=%0b", stale);
  endtask

`ifdef APPROX_ERR_STATS_EN
  task automatic test_stats_clr();
    logic [8:0] s; logic [1:0] mo; bit got;
    run_one(8'h0F, 8'h01, 2'd1, s, mo, got);
    total++; if (err_count !== 32'd1 || err_sum !== 32'd1) begin
      bad++; $display("FAIL clr_pre got=%0d/%0d want=1/1", err_count, err_sum); end
    out_ready = 1'b0; in_mode = 2'd1; in_a = 8'h18; in_b = 8'h08; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (out_valid) got = 1'b1; else begin @(posedge clk); #1; end
    end
    total++; if (!got) begin bad++; $display("FAIL clr_wait got=timeout want=valid"); end
    out_ready = 1'b1; stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    total++; if (err_count !== 32'd0 || err_max !== 9'd0 || err_sum !== 32'd0) begin
      bad++; $display("FAIL clr_wins got=%0d/%0d/%0d want=0/0/0", err_count, err_max, err_sum); end
    $display("txn stats_clr with transfer -> count=%0d max=%0d sum=%0d", err_count, err_max, err_sum);
  endtask
`endif

  initial begin
    test_reset();
    test_exact();
    test_loa();
    test_trunc();
    test_back_to_back();
    test_reset_flight();
`ifdef APPROX_ERR_STATS_EN
    test_stats_clr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
